// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - sequencer for the 5-stage CIC decimator: reset, ratio load, settle discard, sample strobe
// Optional stuck-clock watchdog is built when CIC_WDOG_EN is defined.
module cic_decim_ctrl #(
    parameter int DATA_W         = 31,
    parameter int DEFAULT_RATIO  = 64,
    parameter int MIN_RATIO      = 2,
    parameter int RST_CYCLES     = 4,
    parameter int SETTLE_SAMPLES = 5,
    parameter int WDOG_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cfg_ratio,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              cic_rst,
    output logic [15:0]       cic_ratio,
    input  logic              cic_d_clk,
    input  logic [DATA_W-1:0] cic_d_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy
);
    localparam int RST_CNT_W = ($clog2(RST_CYCLES + 1) > 3) ? $clog2(RST_CYCLES + 1) : 3;
    localparam int SET_CNT_W = ($clog2(SETTLE_SAMPLES + 1) > 1) ? $clog2(SETTLE_SAMPLES + 1) : 1;

    typedef enum logic [1:0] {
        S_RST    = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_cic_rst;
    logic [15:0]           r_cic_ratio;
    logic                  r_cfg_ready;
    logic                  r_cfg_err;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_busy;
    logic [RST_CNT_W-1:0]  r_rst_cnt;
    logic [SET_CNT_W-1:0]  r_settle_cnt;
    logic                  r_d_clk_q;

    logic w_rise;
    logic w_accept;
    logic w_cfg_ok;
    logic w_reconf;
    logic w_reject;
    logic w_settle_last;
    logic w_wdog_trip;

    assign w_rise        = cic_d_clk & ~r_d_clk_q;
    assign w_accept      = cfg_valid & r_cfg_ready;
    assign w_cfg_ok      = (cfg_ratio >= 16'(MIN_RATIO));
    assign w_reconf      = w_accept & w_cfg_ok;
    assign w_reject      = w_accept & ~w_cfg_ok;
    assign w_settle_last = (r_settle_cnt == SET_CNT_W'(SETTLE_SAMPLES - 1));

`ifdef CIC_WDOG_EN
    logic [16:0] r_wdog_cnt;
    logic [17:0] w_wdog_limit;

    // Limit is two output periods plus slack; a healthy decimator rises once per period.
    assign w_wdog_limit = {1'b0, r_cic_ratio, 1'b0} + 18'(WDOG_CYCLES);
    assign w_wdog_trip  = (r_state != S_RST) && !w_rise &&
                          (({1'b0, r_wdog_cnt} + 18'd1) == w_wdog_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if ((r_state == S_RST) || w_rise || w_reconf || w_wdog_trip) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt != '1) begin
            r_wdog_cnt <= r_wdog_cnt + 17'd1;
        end
    end
`else
    assign w_wdog_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RST;
            r_cic_rst    <= 1'b1;
            r_cic_ratio  <= 16'(DEFAULT_RATIO);
            r_cfg_ready  <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_busy       <= 1'b1;
            r_rst_cnt    <= '0;
            r_settle_cnt <= '0;
            r_d_clk_q    <= 1'b0;
        end else begin
            r_d_clk_q   <= cic_d_clk;
            r_out_valid <= 1'b0;
            r_cfg_err   <= w_reject | w_wdog_trip;

            // Reconfiguration outranks a coincident rise: that sample is dropped.
            if (w_reconf || w_wdog_trip) begin
                if (w_reconf) begin
                    r_cic_ratio <= cfg_ratio;
                end
                r_state      <= S_RST;
                r_cic_rst    <= 1'b1;
                r_cfg_ready  <= 1'b0;
                r_busy       <= 1'b1;
                r_rst_cnt    <= '0;
                r_settle_cnt <= '0;
            end else begin
                case (r_state)
                    S_RST: begin
                        if (r_rst_cnt == RST_CNT_W'(RST_CYCLES - 1)) begin
                            r_state     <= S_SETTLE;
                            r_cic_rst   <= 1'b0;
                            r_cfg_ready <= 1'b1;
                            r_rst_cnt   <= '0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (w_rise) begin
                            if (r_settle_cnt != SET_CNT_W'(SETTLE_SAMPLES)) begin
                                r_settle_cnt <= r_settle_cnt + 1'b1;
                            end
                            if (w_settle_last) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_rise) begin
                            r_out_data  <= cic_d_out;
                            r_out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= S_RST;
                        r_cic_rst   <= 1'b1;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign cic_rst   = r_cic_rst;
    assign cic_ratio = r_cic_ratio;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - scoreboard bench for cic_decim_ctrl with a behavioural decimator model
module tb_cic_decim_ctrl;
    localparam int DATA_W = 31;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       cfg_ratio = 16'd0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              cfg_err;
    logic              cic_rst;
    logic [15:0]       cic_ratio;
    logic              cic_d_clk = 1'b0;
    logic [DATA_W-1:0] cic_d_out = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;

    cic_decim_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_ratio(cfg_ratio), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cic_rst(cic_rst), .cic_ratio(cic_ratio),
        .cic_d_clk(cic_d_clk), .cic_d_out(cic_d_out), .out_data(out_data),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int                m_dcnt = 0;
    int                m_rises = 0;
    logic              m_rise = 1'b0;
    logic              m_stuck = 1'b0;
    logic [DATA_W-1:0] m_sample = '0;
    int                m_last_rise_cyc = 0;
    logic              tb_expect_ready = 1'b0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;
    exp_t sb[$];

    // Decimator model: one-cycle d_clk pulse every cic_ratio cycles once out of reset.
    always @(negedge clk) begin
        if (!rst_n || cic_rst) begin
            m_dcnt    = 0;
            m_rises   = 0;
            m_rise    = 1'b0;
            cic_d_clk = 1'b0;
        end else begin
            m_dcnt    = (m_dcnt >= int'(cic_ratio) - 1) ? 0 : m_dcnt + 1;
            m_rise    = (m_dcnt == int'(cic_ratio) - 1) && !m_stuck && !cic_d_clk;
            cic_d_clk = m_rise;
            if (m_rise) begin
                m_rises  = m_rises + 1;
                m_sample = m_sample + 1'b1;
                cic_d_out = m_sample;
            end
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_rise) m_last_rise_cyc = cyc;
        if (m_rise && rst_n && m_rises > 5 &&
            !(cfg_valid && tb_expect_ready && cfg_ratio >= 16'd2))
            sb.push_back('{data: cic_d_out, cyc: cyc});
    end

    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected out_valid at cyc=%0d data=%0d, none expected", cyc, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL sb_sample got data=%0d cyc=%0d exp data=%0d cyc=%0d", out_data, cyc, e.data, e.cyc);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL sb_missing no out_valid at cyc=%0d exp data=%0d", e.cyc, e.data);
        end
    end

    task automatic wait_valid(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (out_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rise_cycle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (m_rise) break;
        end
    endtask

    task automatic test_reset;
        int n, c0, a1, a2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cic_rst !== 1'b1) begin failures++; $display("FAIL rst_cic_rst got=%0b exp=1", cic_rst); end
        checks++; if (cic_ratio !== 16'd64) begin failures++; $display("FAIL rst_cic_ratio got=%0d exp=64", cic_ratio); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_cfg_ready got=%0b exp=0", cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%0b exp=0", cfg_err); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        rst_n = 1'b1;
        c0 = cyc;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cic_rst) break;
            n++;
            @(negedge clk); #1;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL rst_hold_cycles got=%0d exp=4", n); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL settle_cfg_ready got=%0b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL settle_busy got=%0b exp=1", busy); end
        wait_valid(1000, a1);
        checks++; if (a1 - c0 != 4 + 63 + 5 * 64) begin failures++; $display("FAIL first_valid_latency got=%0d exp=%0d", a1 - c0, 4 + 63 + 5 * 64); end
        wait_valid(200, a2);
        checks++; if (a2 - a1 != 64) begin failures++; $display("FAIL spacing_64 got=%0d exp=64", a2 - a1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_bad_ratio;
        int a1, a2;
        wait_rise_cycle(200);
        cfg_ratio = 16'd1; cfg_valid = 1'b1; tb_expect_ready = 1'b1;
        @(negedge clk); #1;
        a1 = cyc;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL bad_err_pulse got=%0b exp=1", cfg_err); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bad_rise_emitted got=%0b exp=1", out_valid); end
        cfg_valid = 1'b0; tb_expect_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL bad_err_single got=%0b exp=0", cfg_err); end
        checks++; if (cic_ratio !== 16'd64) begin failures++; $display("FAIL bad_ratio_kept got=%0d exp=64", cic_ratio); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_busy got=%0b exp=0", busy); end
        wait_valid(200, a2);
        checks++; if (a2 - a1 != 64) begin failures++; $display("FAIL bad_cadence got=%0d exp=64", a2 - a1); end
    endtask

    task automatic test_reconfig;
        int n, a1, a2;
        logic err_seen;
        for (int i = 0; i < 5 && m_rise; i++) begin @(negedge clk); #1; end
        cfg_ratio = 16'd16; cfg_valid = 1'b1; tb_expect_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (cic_ratio !== 16'd16) begin failures++; $display("FAIL reconf_ratio got=%0d exp=16", cic_ratio); end
        checks++; if (cic_rst !== 1'b1) begin failures++; $display("FAIL reconf_cic_rst got=%0b exp=1", cic_rst); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reconf_busy got=%0b exp=1", busy); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reconf_cfg_ready got=%0b exp=0", cfg_ready); end
        cfg_ratio = 16'd32; tb_expect_ready = 1'b0;
        n = 1;
        err_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            cfg_valid = 1'b0;
            err_seen |= cfg_err;
            if (!cic_rst) break;
            n++;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL reconf_hold_cycles got=%0d exp=4", n); end
        checks++; if (cic_ratio !== 16'd16) begin failures++; $display("FAIL ignored_cfg_ratio got=%0d exp=16", cic_ratio); end
        checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL ignored_cfg_err got=%0b exp=0", err_seen); end
        wait_valid(500, a1);
        wait_valid(100, a2);
        checks++; if (a2 - a1 != 16) begin failures++; $display("FAIL spacing_16 got=%0d exp=16", a2 - a1); end
    endtask

    task automatic test_collision;
        int a1, a2;
        wait_rise_cycle(100);
        cfg_ratio = 16'd8; cfg_valid = 1'b1; tb_expect_ready = 1'b1;
        @(negedge clk); #1;
        cfg_valid = 1'b0; tb_expect_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL collide_dropped got=%0b exp=0", out_valid); end
        checks++; if (cic_ratio !== 16'd8) begin failures++; $display("FAIL collide_ratio got=%0d exp=8", cic_ratio); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL collide_err got=%0b exp=0", cfg_err); end
        wait_valid(300, a1);
        wait_valid(100, a2);
        checks++; if (a2 - a1 != 8) begin failures++; $display("FAIL spacing_8 got=%0d exp=8", a2 - a1); end
    endtask

    task automatic test_async_reset;
        int a0, c0, a1;
        wait_valid(100, a0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (cic_rst !== 1'b1) begin failures++; $display("FAIL arst_cic_rst got=%0b exp=1", cic_rst); end
        checks++; if (cic_ratio !== 16'd64) begin failures++; $display("FAIL arst_ratio got=%0d exp=64", cic_ratio); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arst_busy got=%0b exp=1", busy); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL arst_cfg_ready got=%0b exp=0", cfg_ready); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL arst_out_data got=%0d exp=0", out_data); end
        #10 rst_n = 1'b1;
        c0 = cyc;
        wait_valid(1000, a1);
        checks++; if (a1 - c0 != 4 + 63 + 5 * 64) begin failures++; $display("FAIL arst_restart_latency got=%0d exp=%0d", a1 - c0, 4 + 63 + 5 * 64); end
    endtask

    task automatic test_stuck_clock;
        logic err_seen, busy_seen;
        int   err_cyc;
        err_seen = 1'b0; busy_seen = 1'b0; err_cyc = -1;
        m_stuck = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (cfg_err && !err_seen) err_cyc = cyc;
            err_seen |= cfg_err;
            busy_seen |= busy;
        end
`ifdef CIC_WDOG_EN
        checks++; if (err_seen !== 1'b1) begin failures++; $display("FAIL wdog_err got=%0b exp=1", err_seen); end
        checks++; if (err_cyc - m_last_rise_cyc != 2 * 64 + 4) begin failures++; $display("FAIL wdog_delay got=%0d exp=%0d", err_cyc - m_last_rise_cyc, 2 * 64 + 4); end
`else
        checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL stuck_err got=%0b exp=0", err_seen); end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL stuck_busy got=%0b exp=0", busy_seen); end
`endif
        m_stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bad_ratio();
        test_reconfig();
        test_collision();
        test_async_reset();
        test_stuck_clock();
        repeat (5) @(negedge clk);
        #1;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drained got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
